fixed_accum_unit: RTL and testbench

FIXED_ACCUM_UNIT -- requirements
Module: fixed_accum_unit

---
 rtl/fixed_accum_unit.sv | 151 +++++++++++++++
 tb/tb_fixed_accum_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_accum_unit.sv
// fixed_accum_unit: accumulates a run of 'len' signed fixed-point samples into a
// 32-bit sum with ACC_FRAC fraction bits, aligning each sample by its own binary point.
// Latency: result valid one clock after the last accepted beat (one clock after start when len=0).
// Backpressure: in_ready only in ACCUM; the result holds in DONE until out_ready.
// Ports: clk/rst (async active-low) | start, len | in_valid/in_ready/in_data/in_fixpointpos
//        | out_valid/out_ready/out_data/out_ovf (sticky overflow for the run).
// Build option: define FXACC_SAT_EN to saturate on overflow; otherwise results wrap.
module fixed_accum_unit #(
    parameter int ACC_FRAC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_fixpointpos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [6:0] ACC_FRAC_S = 7'(ACC_FRAC);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc;
    logic        ovf;
    logic [7:0]  count;
    logic [7:0]  len_q;
    logic        beat;

    // alignment datapath
    logic signed [6:0] sh;
    logic [4:0]        lamt;
    logic [4:0]        ramt;
    logic [63:0]       lext;
    logic [31:0]       aligned;
    logic              align_ovf;

    // accumulation datapath
    logic [32:0]       sum_ext;
    logic [31:0]       sum;
    logic              sum_ovf;

    assign beat = in_valid && (state == ACCUM);

    always_comb begin
        sh        = ACC_FRAC_S - $signed({2'b00, in_fixpointpos});
        lamt      = sh[4:0];
        ramt      = 5'(-sh);
        // Shift the sign-extended sample in 64 bits so lost magnitude bits stay visible.
        lext      = {{32{in_data[31]}}, in_data} << lamt;
        aligned   = in_data;
        align_ovf = 1'b0;
        if (sh > 7'sd0) begin
            aligned = lext[31:0];
            // Representable only if bits 63..31 are all copies of the sign.
            if (!((&lext[63:31]) || !(|lext[63:31]))) begin
                align_ovf = 1'b1;
`ifdef FXACC_SAT_EN
                aligned = in_data[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
            end
        end else if (sh < 7'sd0) begin
            // Arithmetic right shift truncates toward minus infinity.
            aligned = $unsigned($signed(in_data) >>> ramt);
        end
    end

    always_comb begin
        sum_ext = {acc[31], acc} + {aligned[31], aligned};
        sum_ovf = sum_ext[32] ^ sum_ext[31];
        sum     = sum_ext[31:0];
`ifdef FXACC_SAT_EN
        // Bit 32 carries the true sign of the 33-bit sum.
        if (sum_ovf) begin
            sum = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == 8'd0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat && ((count + 8'd1) == len_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= 32'd0;
            ovf   <= 1'b0;
            count <= 8'd0;
            len_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= 32'd0;
                        ovf   <= 1'b0;
                        count <= 8'd0;
                        len_q <= len;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= sum;
                        ovf   <= ovf | align_ovf | sum_ovf;
                        count <= count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_fixed_accum_unit.sv
// tb_fixed_accum_unit: randomized and directed runs against an arithmetic reference model;
// expected results are queued at stimulus time and checked by a monitor on each output handshake.
module tb_fixed_accum_unit;

    localparam int     ACC_FRAC = 16;
    localparam longint MAXV     = 64'sh7FFF_FFFF;
    localparam longint MINV     = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic [4:0]  in_fixpointpos = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_ovf;

    logic [32:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          rand_rdy = 1'b1;
    logic [31:0] bd[8];
    logic [4:0]  bp[8];

    fixed_accum_unit #(.ACC_FRAC(ACC_FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_fixpointpos(in_fixpointpos), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Range-checks a real-valued intermediate; out-of-range values clamp or wrap.
    function automatic longint fit(input longint v, inout bit o);
        if (v > MAXV || v < MINV) begin
            o = 1'b1;
`ifdef FXACC_SAT_EN
            return (v > 0) ? MAXV : MINV;
`else
            return longint'(int'(v));
`endif
        end
        return v;
    endfunction

    // Sum of samples scaled by 2^(ACC_FRAC-pos), floor rounding for downscaling.
    function automatic logic [32:0] model(input int n);
        longint acc;
        longint v;
        longint d;
        longint q;
        int     sh;
        bit     o;
        acc = 0;
        o   = 1'b0;
        for (int i = 0; i < n; i++) begin
            sh = ACC_FRAC - int'(bp[i]);
            v  = longint'($signed(bd[i]));
            if (sh >= 0) begin
                v = v * (longint'(1) << sh);
            end else begin
                d = longint'(1) << (-sh);
                q = v / d;
                if ((q * d != v) && (v < 0)) q = q - 1;
                v = q;
            end
            v   = fit(v, o);
            acc = fit(acc + v, o);
        end
        return {o, acc[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = rand_rdy ? 1'($urandom % 2) : 1'b0;
    endtask

    task automatic do_run(input int n, input bit use_exp, input logic [32:0] ev, input bit hold);
        logic [32:0] e;
        int          guard;
        bit          accepted;
        e = use_exp ? ev : model(n);
        exp_q.push_back(e);
        if (hold) rand_rdy = 1'b0;
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        if (n == 0) chk("len0_latency", out_valid, 1);
        for (int i = 0; i < n; i++) begin
            guard    = 0;
            accepted = 1'b0;
            while (!accepted && guard < 50) begin
                in_valid       = ($urandom % 4) != 0;
                in_data        = bd[i];
                in_fixpointpos = bp[i];
                start          = 1'($urandom % 2);   // must be ignored in ACCUM
                len            = 8'($urandom);
                accepted       = in_valid && in_ready;
                tick();
                guard++;
            end
            if (!accepted) fail_now("beat_accept");
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (n > 0) begin
            chk("last_beat_latency", out_valid, 1);
            chk("done_in_ready", in_ready, 0);
        end
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                start = 1'b1;
                len   = 8'd5;
                tick();
                chk("hold_result", {out_ovf, out_data}, e);
                chk("hold_valid", out_valid, 1);
                chk("hold_in_ready", in_ready, 0);
            end
            start     = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("release_to_idle", out_valid, 0);
            rand_rdy  = 1'b1;
            out_ready = 1'b0;
        end else begin
            guard = 0;
            while (exp_q.size() != 0 && guard < 200) begin
                in_valid = 1'($urandom % 2);     // must be ignored in DONE
                in_data  = $urandom;
                tick();
                guard++;
            end
            in_valid = 1'b0;
            if (exp_q.size() != 0) begin
                fail_now("result_handshake");
                exp_q.delete();
            end
        end
    endtask

    initial begin
        fork
            forever begin
                logic [32:0] e;
                @(negedge clk);
                if (rst && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result: got %h with no expectation queued",
                                 {out_ovf, out_data});
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {out_ovf, out_data}, e);
                    end
                end
            end
        join_none

        #3;
        chk("reset_outputs", {out_valid, in_ready, out_ovf, out_data}, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        bd[0] = 32'h0000_0065; bp[0] = 5'd2;
        do_run(1, 1'b1, {1'b0, 32'h0019_4000}, 1'b0);

        bd[1] = 32'hFFFF_FF9B; bp[1] = 5'd2;
        do_run(2, 1'b1, {1'b0, 32'h0000_0000}, 1'b0);

        bd[0] = 32'h0010_0000; bp[0] = 5'd20;
        do_run(1, 1'b1, {1'b0, 32'h0001_0000}, 1'b0);

        bd[0] = 32'h0001_0000; bp[0] = 5'd0;
`ifdef FXACC_SAT_EN
        do_run(1, 1'b1, {1'b1, 32'h7FFF_FFFF}, 1'b0);
`else
        do_run(1, 1'b1, {1'b1, 32'h0000_0000}, 1'b0);
`endif

        bd[0] = 32'h7FFF_0000; bp[0] = 5'd16;
        bd[1] = 32'h0002_0000; bp[1] = 5'd16;
`ifdef FXACC_SAT_EN
        do_run(2, 1'b1, {1'b1, 32'h7FFF_FFFF}, 1'b0);
`else
        do_run(2, 1'b1, {1'b1, 32'h8001_0000}, 1'b0);
`endif

        do_run(0, 1'b1, {1'b0, 32'h0000_0000}, 1'b0);

        bd[0] = 32'h0000_0065; bp[0] = 5'd2;
        do_run(1, 1'b1, {1'b0, 32'h0019_4000}, 1'b1);

        // Reset in the middle of a len=4 run.
        bd[0] = 32'h0000_0065; bp[0] = 5'd2;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = bd[0]; in_fixpointpos = bp[0];
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrun_reset", {out_valid, in_ready, out_ovf, out_data}, 0);
        tick();
        rst = 1'b1;
        tick();
        bd[0] = 32'h0001_0000; bp[0] = 5'd16;
        do_run(1, 1'b1, {1'b0, 32'h0001_0000}, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) begin
                bd[i] = $urandom;
                if ($urandom % 2) bd[i] = $unsigned($signed(bd[i]) >>> $urandom_range(0, 24));
                bp[i] = 5'($urandom_range(0, 31));
            end
            do_run(n, 1'b0, 33'd0, 1'b0);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
